gpio_bank: RTL

- Parametrised GPIO peripheral for the j1 I/O bus. Generalises the top-level bit-addressed GPO/GPIO-direction/GPI registers into a self-contained block.
- Configurable pin count and input synchroniser depth.
- Adds per-pin rising/falling edge capture, sticky event flags, an interrupt output, and a lowest-pending-pin priority readout.
- Sits behind the top-level I/O address decode. The top keeps the tristate buffers: pin = oe ? out : z.

---
 rtl/gpio_pkg.sv | 26 ++
 rtl/gpio_bank_if.sv | 24 ++
 rtl/gpio_sync_edge.sv | 38 +++
 rtl/gpio_bank.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// gpio_bank shared definitions: register selects and index widths.
// Imported by every gpio_bank design file.
package gpio_pkg;

  localparam int PIN_IDX_W = 7;
  localparam int MAX_PINS  = 128;

  typedef enum logic [2:0] {
    REG_DATA    = 3'd0,
    REG_DIR     = 3'd1,
    REG_RISE_EN = 3'd2,
    REG_FALL_EN = 3'd3,
    REG_EVENT   = 3'd4,
    REG_OUT     = 3'd5,
    REG_FIRST   = 3'd6,
    REG_RSVD    = 3'd7
  } reg_sel_e;

  function automatic logic [31:0] first_word(
    input logic                 vld,
    input logic [PIN_IDX_W-1:0] idx
  );
    return vld ? {1'b1, 24'd0, idx} : 32'd0;
  endfunction

endpackage

// File: rtl/gpio_bank_if.sv
// j1 I/O bus slice seen by gpio_bank.
// Write strobe, address and data in; registered read data out.
interface gpio_bank_if;

  logic        io_wr;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output io_wr,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  io_wr,
    input  addr,
    input  wdata,
    output rdata
  );

endinterface

// File: rtl/gpio_sync_edge.sv
// Per-pin input synchroniser with one-cycle-delayed copy
// for rising/falling edge detection.
module gpio_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_async,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_async};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

endmodule

// File: rtl/gpio_bank.sv
// Bit-addressed GPIO bank: outputs, directions, edge-capture
// flags with irq, and lowest-pending-pin readout.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int PINS        = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  gpio_bank_if.slave      bus,
  input  logic [PINS-1:0] pin_in,
  output logic [PINS-1:0] pin_out,
  output logic [PINS-1:0] pin_oe,
  output logic            irq
);

  reg_sel_e              reg_sel;
  logic [MAX_PINS-1:0]   sel_full;
  logic [PINS-1:0]       sel;
  logic                  in_range;
  logic                  wr_bit;

  logic [PINS-1:0]       sync_in;
  logic [PINS-1:0]       rise;
  logic [PINS-1:0]       fall;

  logic [PINS-1:0]       out_q,     out_d;
  logic [PINS-1:0]       oe_q,      oe_d;
  logic [PINS-1:0]       rise_en_q, rise_en_d;
  logic [PINS-1:0]       fall_en_q, fall_en_d;
  logic [PINS-1:0]       event_q,   event_d;
  logic [PINS-1:0]       clr;
  logic [PINS-1:0]       evt_set;
  logic [31:0]           rdata_q,   rdata_d;

  logic                  first_vld;
  logic [PIN_IDX_W-1:0]  first_idx;

  logic                  unused_bits;
  assign unused_bits = ^{bus.addr[15:11], bus.addr[7],
                         bus.wdata[31:1], sel_full};

  for (genvar g = 0; g < PINS; g++) begin : g_pin
    gpio_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
      .clk     (clk),
      .reset   (reset),
      .d_async (pin_in[g]),
      .sync    (sync_in[g]),
      .rise    (rise[g]),
      .fall    (fall[g])
    );
  end

  // A one-hot pin mask truncated to PINS makes out-of-range
  // indices select nothing, for both reads and writes.
  always_comb begin
    reg_sel  = reg_sel_e'(bus.addr[10:8]);
    sel_full = MAX_PINS'(1) << bus.addr[6:0];
    sel      = sel_full[PINS-1:0];
    in_range = |sel;
    wr_bit   = bus.wdata[0];
  end

  always_comb begin
    out_d     = out_q;
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    clr       = '0;
    if (bus.io_wr) begin
      case (reg_sel)
        REG_DATA, REG_OUT:
          out_d = wr_bit ? (out_q | sel) : (out_q & ~sel);
        REG_DIR:
          oe_d = wr_bit ? (oe_q | sel) : (oe_q & ~sel);
        REG_RISE_EN:
          rise_en_d = wr_bit ? (rise_en_q | sel)
                             : (rise_en_q & ~sel);
        REG_FALL_EN:
          fall_en_d = wr_bit ? (fall_en_q | sel)
                             : (fall_en_q & ~sel);
        REG_EVENT:
          clr = wr_bit ? sel : '0;
        default: ;
      endcase
    end
  end

  // Set beats clear so an edge landing on a clear is kept.
  always_comb begin
    evt_set = (rise & rise_en_q) | (fall & fall_en_q);
    event_d = (event_q & ~clr) | evt_set;
  end

  always_comb begin
    first_vld = 1'b0;
    first_idx = '0;
    for (int i = PINS - 1; i >= 0; i--) begin
      if (event_q[i]) begin
        first_vld = 1'b1;
        first_idx = PIN_IDX_W'(i);
      end
    end
  end

  always_comb begin
    rdata_d = 32'd0;
    case (reg_sel)
      REG_DATA:    rdata_d = {31'd0, |(sync_in & sel)};
      REG_DIR:     rdata_d = {31'd0, |(oe_q & sel)};
      REG_RISE_EN: rdata_d = {31'd0, |(rise_en_q & sel)};
      REG_FALL_EN: rdata_d = {31'd0, |(fall_en_q & sel)};
      REG_EVENT:   rdata_d = {31'd0, |(event_q & sel)};
      REG_OUT:     rdata_d = {31'd0, |(out_q & sel)};
      REG_FIRST:
        rdata_d = in_range ? first_word(first_vld, first_idx)
                           : 32'd0;
      default:     rdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      event_q   <= '0;
      rdata_q   <= '0;
    end else begin
      out_q     <= out_d;
      oe_q      <= oe_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      event_q   <= event_d;
      rdata_q   <= rdata_d;
    end
  end

  assign pin_out   = out_q;
  assign pin_oe    = oe_q;
  assign irq       = |event_q;
  assign bus.rdata = rdata_q;

endmodule
